// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and EMPTY/FULL flags decoded
// from a registered occupancy count; illegal accesses are ignored internally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             WR_EN,
  input  logic             RD_EN,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             EMPTY,
  output logic             FULL
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW:0]      count;
  logic             wr_ok;
  logic             rd_ok;

  assign EMPTY = (count == '0);
  assign FULL  = (count == (AW+1)'(DEPTH));

  // A write while full is legal only because the same-cycle read frees a slot.
  assign rd_ok = RD_EN && !EMPTY;
  assign wr_ok = WR_EN && (!FULL || rd_ok);

  always_ff @(posedge CLK) begin
    if (wr_ok && !RST) begin
      mem[wp] <= DATA_IN;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      DATA_OUT <= '0;
    end else begin
      if (wr_ok) begin
        wp <= wp + AW'(1);
      end
      if (rd_ok) begin
        rp       <= rp + AW'(1);
        DATA_OUT <= mem[rp];
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: table-driven vectors for fill, overflow,
// full read/write and empty boundary, plus hand sequences for wrap and async reset.
module tb_sync_fifo;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] DATA_IN;
  logic       WR_EN;
  logic       RD_EN;
  logic [7:0] DATA_OUT;
  logic       EMPTY;
  logic       FULL;

  int passed = 0;
  int total  = 0;

  sync_fifo #(.WIDTH(8), .DEPTH(8)) dut (
    .CLK(CLK),
    .RST(RST),
    .DATA_IN(DATA_IN),
    .WR_EN(WR_EN),
    .RD_EN(RD_EN),
    .DATA_OUT(DATA_OUT),
    .EMPTY(EMPTY),
    .FULL(FULL)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic [7:0] dout;
    logic       empty;
    logic       full;
  } vec_t;

  vec_t vecs[64];
  int   nvec = 0;

  task automatic add(input logic wr, input logic rd, input logic [7:0] din,
                     input logic [7:0] dout, input logic empty, input logic full);
    vecs[nvec] = '{wr, rd, din, dout, empty, full};
    nvec++;
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
  endtask

  task automatic check_outs(input string tag, input int idx, input logic [7:0] dout,
                            input logic empty, input logic full);
    chk({tag, ".dout"},  idx, DATA_OUT, dout);
    chk({tag, ".empty"}, idx, {7'd0, EMPTY}, {7'd0, empty});
    chk({tag, ".full"},  idx, {7'd0, FULL},  {7'd0, full});
  endtask

  // Drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic wr, input logic rd, input logic [7:0] din);
    @(negedge CLK);
    WR_EN   = wr;
    RD_EN   = rd;
    DATA_IN = din;
    @(posedge CLK);
    #1;
  endtask

  logic [7:0] sd [20];

  initial begin
    RST = 1'b1; WR_EN = 1'b0; RD_EN = 1'b0; DATA_IN = '0;

    // Vector table: expected values are the state just after each edge.
    add(1, 0, 8'd1, 8'd0, 0, 0);
    add(1, 1, 8'd2, 8'd1, 0, 0);
    for (int i = 1; i <= 7; i++) add(1, 0, 8'(i * 10), 8'd1, 0, (i == 7));
    for (int i = 8; i <= 13; i++) add(1, 0, 8'(i * 10), 8'd1, 0, 1);
    add(0, 1, 8'd0, 8'd2, 0, 0);
    for (int i = 1; i <= 7; i++) add(0, 1, 8'd0, 8'(i * 10), (i == 7), 0);
    for (int i = 0; i < 8; i++) add(1, 0, 8'(200 + i), 8'd70, 0, (i == 7));
    add(1, 1, 8'd140, 8'd200, 0, 1);
    for (int i = 1; i <= 7; i++) add(0, 1, 8'd0, 8'(200 + i), 0, 0);
    add(0, 1, 8'd0, 8'd140, 1, 0);
    add(0, 1, 8'd0, 8'd140, 1, 0);
    add(1, 0, 8'd5, 8'd140, 0, 0);
    add(0, 1, 8'd0, 8'd5, 1, 0);

    #2;
    check_outs("reset", 0, 8'd0, 1, 0);
    @(negedge CLK);
    RST = 1'b0;

    for (int v = 0; v < nvec; v++) begin
      step(vecs[v].wr, vecs[v].rd, vecs[v].din);
      check_outs("vec", v, vecs[v].dout, vecs[v].empty, vecs[v].full);
    end

    // Stream 20 words at one per cycle across the pointer wrap.
    for (int k = 0; k < 20; k++) sd[k] = 8'((k * 11 + 3) % 256);
    step(1, 0, sd[0]);
    chk("stream.empty", 0, {7'd0, EMPTY}, 8'd0);
    for (int k = 1; k < 20; k++) begin
      step(1, 1, sd[k]);
      chk("stream.dout", k, DATA_OUT, sd[k-1]);
      chk("stream.empty", k, {7'd0, EMPTY}, 8'd0);
    end
    step(0, 1, 8'd0);
    check_outs("stream_end", 20, sd[19], 1, 0);

    // Fill, then assert reset between clock edges.
    for (int i = 0; i < 8; i++) step(1, 0, 8'(90 + i));
    check_outs("prefill", 0, sd[19], 0, 1);
    @(negedge CLK);
    WR_EN = 1'b0;
    RD_EN = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    check_outs("async_rst", 0, 8'd0, 1, 0);
    @(negedge CLK);
    RST = 1'b0;
    step(1, 0, 8'd33);
    check_outs("post_rst_wr", 0, 8'd0, 0, 0);
    step(0, 1, 8'd0);
    check_outs("post_rst_rd", 0, 8'd33, 1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1);
  end

endmodule
